// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state/cause encodings for the CPU run controller
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    BREAK  = 2'd3
  } run_state_t;

  typedef enum logic [1:0] {
    HC_NONE   = 2'd0,
    HC_USER   = 2'd1,
    HC_BP     = 2'd2,
    HC_EBREAK = 2'd3
  } halt_cause_t;

  localparam logic [31:0] EBREAK_INSTR_DEFAULT = 32'h00100073;

endpackage

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - 2-flop sync, optional debounce filter, rising-edge detect
// DEBOUNCE_CYCLES = 0 removes the filter entirely.
module input_conditioner #(
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic sync1, sync2, prev_level, filt_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      prev_level <= 1'b0;
    end else begin
      sync1      <= raw ^ ACTIVE_LOW;
      sync2      <= sync1;
      prev_level <= filt_level;
    end
  end

  generate
    if (DEBOUNCE_CYCLES > 0) begin : g_debounce
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      logic [CNT_W-1:0] cnt;
      logic             db_level;

      // Counter runs only while the synced input disagrees with the filtered level.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt      <= '0;
          db_level <= 1'b0;
        end else if (sync2 == db_level) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt      <= '0;
          db_level <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign filt_level = db_level;
    end else begin : g_no_debounce
      assign filt_level = sync2;
    end
  endgenerate

  assign level = filt_level;
  assign rise  = filt_level & ~prev_level;

endmodule

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run/step/breakpoint sequencer gating core commits; step debounce via RUN_CTRL_DEBOUNCE_EN
module cpu_run_controller
  import run_ctrl_pkg::*;
#(
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter logic [31:0] EBREAK_INSTR    = EBREAK_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic        cpu_en,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] retired_count
);

`ifdef RUN_CTRL_DEBOUNCE_EN
  localparam int STEP_DEBOUNCE = DEBOUNCE_CYCLES;
`else
  localparam int STEP_DEBOUNCE = 0;
`endif

  logic        run_level, run_rise, step_pulse;
  logic        bp_hit, eb_hit;
  logic        first_cycle;
  run_state_t  state;
  halt_cause_t cause_q;

  input_conditioner #(
    .ACTIVE_LOW      (1'b0),
    .DEBOUNCE_CYCLES (0)
  ) u_run_cond (
    .clk   (clk),
    .reset (reset),
    .raw   (run_sw),
    .level (run_level),
    .rise  (run_rise)
  );

  input_conditioner #(
    .ACTIVE_LOW      (BTN_ACTIVE_LOW),
    .DEBOUNCE_CYCLES (STEP_DEBOUNCE)
  ) u_step_cond (
    .clk   (clk),
    .reset (reset),
    .raw   (step_btn),
    .level (),
    .rise  (step_pulse)
  );

  assign bp_hit = bp_en && (pc == bp_addr);
  assign eb_hit = (instruction == EBREAK_INSTR);

  // The first RUN cycle ignores matches so the core can resume past a stop point.
  always_comb begin
    cpu_en = 1'b0;
    case (state)
      STEP:    cpu_en = 1'b1;
      RUN:     cpu_en = run_level && !(!first_cycle && (eb_hit || bp_hit));
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HALTED;
      halted        <= 1'b1;
      cause_q       <= HC_USER;
      first_cycle   <= 1'b0;
      retired_count <= '0;
    end else begin
      if (cpu_en) retired_count <= retired_count + 32'd1;

      case (state)
        HALTED: begin
          if (run_rise) begin
            state       <= RUN;
            halted      <= 1'b0;
            cause_q     <= HC_NONE;
            first_cycle <= 1'b1;
          end else if (step_pulse) begin
            state  <= STEP;
            halted <= 1'b0;
          end
        end
        STEP: begin
          state   <= HALTED;
          halted  <= 1'b1;
          cause_q <= HC_USER;
        end
        RUN: begin
          first_cycle <= 1'b0;
          if (!run_level) begin
            state   <= HALTED;
            halted  <= 1'b1;
            cause_q <= HC_USER;
          end else if (!first_cycle && (eb_hit || bp_hit)) begin
            state   <= BREAK;
            halted  <= 1'b1;
            cause_q <= eb_hit ? HC_EBREAK : HC_BP;
          end
        end
        BREAK: begin
          if (!run_level) begin
            state <= HALTED;
          end else if (step_pulse) begin
            state  <= STEP;
            halted <= 1'b0;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

  assign halt_cause = cause_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - directed self-checking bench for cpu_run_controller
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        reset, run_sw, step_btn, bp_en;
  logic [31:0] bp_addr, pc, instruction;
  logic        cpu_en, halted;
  logic [1:0]  halt_cause;
  logic [31:0] retired_count;

  logic [31:0] core_pc;
  logic        eb_on;
  logic [31:0] eb_addr;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  cpu_run_controller dut (
    .clk           (clk),
    .reset         (reset),
    .run_sw        (run_sw),
    .step_btn      (step_btn),
    .bp_en         (bp_en),
    .bp_addr       (bp_addr),
    .pc            (pc),
    .instruction   (instruction),
    .cpu_en        (cpu_en),
    .halted        (halted),
    .halt_cause    (halt_cause),
    .retired_count (retired_count)
  );

  // Minimal core: PC advances by 4 on every committed cycle.
  always @(posedge clk) begin
    if (reset) core_pc <= 32'h0;
    else if (cpu_en) core_pc <= core_pc + 32'd4;
  end
  assign pc          = core_pc;
  assign instruction = (eb_on && core_pc == eb_addr) ? 32'h00100073 : 32'h00000013;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; run_sw = 1'b0; step_btn = 1'b1;
    bp_en = 1'b0; bp_addr = 32'h0; eb_on = 1'b0; eb_addr = 32'h0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      tick();
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL reset_halted cyc%0d: got %0b want 1", i, halted); end
      total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL reset_cpu_en cyc%0d: got %0b want 0", i, cpu_en); end
    end
    total++; if (retired_count !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", retired_count); end
    total++; if (halt_cause !== 2'd1) begin bad++; $display("FAIL reset_cause: got %0d want 1", halt_cause); end
  endtask

  task automatic test_step();
    int n = 0;
    int first_at = -1;
    step_btn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (cpu_en === 1'b1) begin
        n++;
        if (first_at < 0) first_at = i;
      end
    end
    total++; if (n != 1) begin bad++; $display("FAIL step_commits: got %0d want 1", n); end
    total++; if (first_at != 3) begin bad++; $display("FAIL step_latency: got %0d want 3", first_at); end
    total++; if (retired_count !== 32'd1) begin bad++; $display("FAIL step_count: got %0d want 1", retired_count); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL step_halted: got %0b want 1", halted); end
    total++; if (halt_cause !== 2'd1) begin bad++; $display("FAIL step_cause: got %0d want 1", halt_cause); end
    step_btn = 1'b1;
    repeat (5) tick();
    total++; if (retired_count !== 32'd1) begin bad++; $display("FAIL step_release: got %0d want 1", retired_count); end
  endtask

  task automatic test_run();
    do_reset();
    run_sw = 1'b1;
    tick();
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL run_lat1: got %0b want 0", cpu_en); end
    tick();
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL run_lat2: got %0b want 0", cpu_en); end
    tick();
    total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL run_lat3: got %0b want 1", cpu_en); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL run_halted: got %0b want 0", halted); end
    total++; if (halt_cause !== 2'd0) begin bad++; $display("FAIL run_cause: got %0d want 0", halt_cause); end
    repeat (50) tick();
    total++; if (retired_count !== 32'd50) begin bad++; $display("FAIL run_count50: got %0d want 50", retired_count); end
    run_sw = 1'b0;
    repeat (2) tick();
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL run_stop_en: got %0b want 0", cpu_en); end
    tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL run_stop_halted: got %0b want 1", halted); end
    total++; if (halt_cause !== 2'd1) begin bad++; $display("FAIL run_stop_cause: got %0d want 1", halt_cause); end
    total++; if (retired_count !== 32'd52) begin bad++; $display("FAIL run_stop_count: got %0d want 52", retired_count); end
  endtask

  task automatic test_breakpoint();
    do_reset();
    bp_en = 1'b1; bp_addr = 32'h20;
    run_sw = 1'b1;
    repeat (11) tick();
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL bp_en_at_hit: got %0b want 0", cpu_en); end
    total++; if (pc !== 32'h20) begin bad++; $display("FAIL bp_pc: got %h want 00000020", pc); end
    total++; if (retired_count !== 32'd8) begin bad++; $display("FAIL bp_count: got %0d want 8", retired_count); end
    tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL bp_halted: got %0b want 1", halted); end
    total++; if (halt_cause !== 2'd2) begin bad++; $display("FAIL bp_cause: got %0d want 2", halt_cause); end
    step_btn = 1'b0;
    repeat (2) tick();
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL bp_step_early: got %0b want 0", cpu_en); end
    tick();
    total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL bp_step_en: got %0b want 1", cpu_en); end
    total++; if (pc !== 32'h20) begin bad++; $display("FAIL bp_step_pc: got %h want 00000020", pc); end
    tick();
    total++; if (retired_count !== 32'd9) begin bad++; $display("FAIL bp_step_count: got %0d want 9", retired_count); end
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL bp_step_once: got %0b want 0", cpu_en); end
    total++; if (halt_cause !== 2'd1) begin bad++; $display("FAIL bp_step_cause: got %0d want 1", halt_cause); end
    step_btn = 1'b1; run_sw = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_ebreak();
    do_reset();
    bp_en = 1'b1; bp_addr = 32'h10; eb_on = 1'b1; eb_addr = 32'h10;
    run_sw = 1'b1;
    repeat (7) tick();
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL eb_en_at_hit: got %0b want 0", cpu_en); end
    total++; if (retired_count !== 32'd4) begin bad++; $display("FAIL eb_count: got %0d want 4", retired_count); end
    tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL eb_halted: got %0b want 1", halted); end
    total++; if (halt_cause !== 2'd3) begin bad++; $display("FAIL eb_cause: got %0d want 3", halt_cause); end
    run_sw = 1'b0;
    repeat (3) tick();
    total++; if (halt_cause !== 2'd3) begin bad++; $display("FAIL eb_cause_hold: got %0d want 3", halt_cause); end
    run_sw = 1'b1;
    repeat (3) tick();
    total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL eb_resume_en: got %0b want 1", cpu_en); end
    total++; if (halt_cause !== 2'd0) begin bad++; $display("FAIL eb_resume_cause: got %0d want 0", halt_cause); end
    total++; if (pc !== 32'h10) begin bad++; $display("FAIL eb_resume_pc: got %h want 00000010", pc); end
    tick();
    total++; if (retired_count !== 32'd5) begin bad++; $display("FAIL eb_resume_count: got %0d want 5", retired_count); end
    total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL eb_resume_next: got %0b want 1", cpu_en); end
  endtask

  task automatic test_reset_mid_run();
    reset = 1'b1; run_sw = 1'b0;
    tick();
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL midrst_en: got %0b want 0", cpu_en); end
    total++; if (retired_count !== 32'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", retired_count); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL midrst_halted: got %0b want 1", halted); end
    total++; if (halt_cause !== 2'd1) begin bad++; $display("FAIL midrst_cause: got %0d want 1", halt_cause); end
    reset = 1'b0;
    repeat (5) tick();
    total++; if (retired_count !== 32'd0) begin bad++; $display("FAIL midrst_after: got %0d want 0", retired_count); end
  endtask

  task automatic test_priority();
    do_reset();
    run_sw = 1'b1; step_btn = 1'b0;
    repeat (3) tick();
    total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL prio_en: got %0b want 1", cpu_en); end
    tick();
    total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL prio_still_run: got %0b want 1", cpu_en); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL prio_halted: got %0b want 0", halted); end
    total++; if (retired_count !== 32'd1) begin bad++; $display("FAIL prio_count: got %0d want 1", retired_count); end
    step_btn = 1'b1; run_sw = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1; run_sw = 1'b0; step_btn = 1'b1;
    bp_en = 1'b0; bp_addr = 32'h0; eb_on = 1'b0; eb_addr = 32'h0;
    test_reset();
    test_step();
    test_run();
    test_breakpoint();
    test_ebreak();
    test_reset_mid_run();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
